// File: rtl/sap1_loader.sv
// sap1_loader: streams program bytes into SAP-1 RAM one strobed write at a time,
// then holds the CPU in clear for CLR_CYCLES cycles and pulses done.
module sap1_loader #(
    parameter int WORDS      = 16,
    parameter int CLR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       prog,
    output logic       write,
    output logic [3:0] a,
    output logic [7:0] d,
    output logic       cpu_clr,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, ACCEPT, SETUP, STROBE, HOLD, CPUCLR, FIN} state_t;

    localparam logic [3:0] LAST     = 4'(WORDS - 1);
    localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);

    state_t     state, nxt;
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            a     <= 4'd0;
            d     <= 8'd0;
            cnt   <= 4'd0;
        end else begin
            state <= nxt;
            cnt   <= (state == CPUCLR) ? cnt + 4'd1 : 4'd0;
            if (state == IDLE && start)
                a <= 4'd0;
            if (state == ACCEPT && in_valid)
                d <= in_data;
            // the last address is never incremented past, so a cannot wrap
            if (state == HOLD && a != LAST)
                a <= a + 4'd1;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = ACCEPT;
            ACCEPT:  if (in_valid) nxt = SETUP;
            SETUP:   nxt = STROBE;
            STROBE:  nxt = HOLD;
            HOLD:    nxt = (a == LAST) ? CPUCLR : ACCEPT;
            CPUCLR:  if (cnt == CLR_LAST) nxt = FIN;
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign in_ready = state == ACCEPT;
    assign prog     = state inside {ACCEPT, SETUP, STROBE, HOLD};
    assign write    = state == STROBE;
    assign cpu_clr  = state == CPUCLR;
    assign busy     = state != IDLE;
    assign done     = state == FIN;
endmodule
